// File: rtl/dram_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and constants for the DRAM line-transaction sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/dram_mem_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way combinational round-robin arbiter (bit 0 = I, bit 1 = D).
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2
    import mem_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie the requester that was not served last wins.
        if (req == 2'b11) begin
            gnt = (last == OWN_D) ? 2'b01 : 2'b10;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dram_mem_ctrl
// Purpose  : Arbitrates I/D cache line transactions onto a single-port memory
//            with a programmable access latency and fixed-length word bursts.
// Revision : 1.0  initial release
// ============================================================================
module dram_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  i_gnt,
    output logic                  d_gnt,
    output logic [3:0]            beat,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  i_rvalid,
    output logic                  d_rvalid,
    output logic                  d_wready,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam int                    LINE_BYTES = BURST_LEN * WORD_BYTES;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~(ADDR_WIDTH'(LINE_BYTES - 1));
    localparam logic [3:0]            LAST_BEAT  = 4'(BURST_LEN - 1);
    localparam logic [3:0]            WAIT_INIT  = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t                state_q, state_d;
    owner_t                owner_q, owner_d;
    owner_t                rr_last_q, rr_last_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [3:0]            beat_q, beat_d;
    logic [1:0]            arb_gnt;
    logic [ADDR_WIDTH-1:0] beat_addr;

    rr_arb2 u_arb (
        .req  ({d_req, i_req}),
        .last (rr_last_q),
        .gnt  (arb_gnt)
    );

    assign beat_addr = base_q + (ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(WORD_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            rr_last_q <= OWN_D;
            we_q      <= 1'b0;
            base_q    <= '0;
            wcnt_q    <= '0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            base_q    <= base_d;
            wcnt_q    <= wcnt_d;
            beat_q    <= beat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        we_d       = we_q;
        base_d     = base_q;
        wcnt_d     = wcnt_q;
        beat_d     = beat_q;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        beat       = 4'd0;
        rdata      = '0;
        i_rvalid   = 1'b0;
        d_rvalid   = 1'b0;
        d_wready   = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        mem_re     = 1'b0;
        mem_r_addr = '0;
        mem_we     = 1'b0;
        mem_w_addr = '0;
        mem_wd     = '0;

        case (state_q)
            IDLE: begin
                i_gnt = arb_gnt[0];
                d_gnt = arb_gnt[1];
                if (arb_gnt != 2'b00) begin
                    owner_d = arb_gnt[1] ? OWN_D : OWN_I;
                    we_d    = arb_gnt[1] & d_we;
                    base_d  = (arb_gnt[1] ? d_addr : i_addr) & LINE_MASK;
                    wcnt_d  = WAIT_INIT;
                    beat_d  = 4'd0;
                    state_d = (LATENCY == 0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == 4'd0) begin
                    beat_d  = 4'd0;
                    state_d = BURST;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            BURST: begin
                beat = beat_q;
                if (we_q) begin
                    mem_we     = 1'b1;
                    mem_w_addr = beat_addr;
                    mem_wd     = d_wdata;
                    d_wready   = 1'b1;
                end else begin
                    mem_re     = 1'b1;
                    mem_r_addr = beat_addr;
                    rdata      = mem_rd;
                    i_rvalid   = (owner_q == OWN_I);
                    d_rvalid   = (owner_q == OWN_D);
                end
                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            DONE: begin
                i_done    = (owner_q == OWN_I);
                d_done    = (owner_q == OWN_D);
                rr_last_d = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dram_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_mem_ctrl
// Purpose  : Self-checking bench: transaction-timeline reference model for the
//            main controller plus a directed zero-latency instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_dram_mem_ctrl;

    localparam int          BL        = 4;
    localparam int          LAT       = 2;
    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] L0_XOR    = 32'h5A5A0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (LATENCY = 2)
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, wseed;
    logic        i_gnt, d_gnt, i_rvalid, d_rvalid, d_wready, i_done, d_done, mem_re, mem_we;
    logic [3:0]  beat;
    logic [31:0] rdata, mem_r_addr, mem_w_addr, mem_wd, mem_rd;
    logic [31:0] env_mem [MEM_WORDS];

    assign d_wdata = wseed + {28'h0, beat};
    assign mem_rd  = env_mem[mem_r_addr[11:2]];
    always @(posedge clk) if (mem_we) env_mem[mem_w_addr[11:2]] <= mem_wd;

    dram_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(BL), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_gnt(i_gnt), .d_gnt(d_gnt), .beat(beat), .rdata(rdata),
        .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .d_wready(d_wready),
        .i_done(i_done), .d_done(d_done),
        .mem_re(mem_re), .mem_r_addr(mem_r_addr),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // zero-latency instance; its memory returns address ^ L0_XOR
    logic        l0_i_req, l0_d_req, l0_d_we;
    logic [31:0] l0_addr, l0_d_wdata;
    logic        l0_i_gnt, l0_d_gnt, l0_i_rvalid, l0_d_rvalid, l0_d_wready, l0_i_done, l0_d_done;
    logic        l0_mem_re, l0_mem_we;
    logic [3:0]  l0_beat;
    logic [31:0] l0_rdata, l0_mem_r_addr, l0_mem_w_addr, l0_mem_wd, l0_mem_rd;

    assign l0_d_wdata = 32'hB0 + {28'h0, l0_beat};
    assign l0_mem_rd  = l0_mem_r_addr ^ L0_XOR;

    dram_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(BL), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(l0_i_req), .i_addr(l0_addr),
        .d_req(l0_d_req), .d_we(l0_d_we), .d_addr(l0_addr), .d_wdata(l0_d_wdata),
        .i_gnt(l0_i_gnt), .d_gnt(l0_d_gnt), .beat(l0_beat), .rdata(l0_rdata),
        .i_rvalid(l0_i_rvalid), .d_rvalid(l0_d_rvalid), .d_wready(l0_d_wready),
        .i_done(l0_i_done), .d_done(l0_d_done),
        .mem_re(l0_mem_re), .mem_r_addr(l0_mem_r_addr),
        .mem_we(l0_mem_we), .mem_w_addr(l0_mem_w_addr), .mem_wd(l0_mem_wd), .mem_rd(l0_mem_rd)
    );

    // Reference model: a transaction is a timeline t = 0 (grant) .. LAT+BL+1 (done).
    logic [31:0] ref_mem [MEM_WORDS];
    bit          m_busy;
    int          m_t, m_owner, m_last, last_g;
    bit          m_we;
    logic [31:0] m_base, m_seed;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h00010000 | 32'($urandom_range(0, 4095));
    endfunction

    // One clock cycle: check outputs at negedge, advance model at posedge.
    // Unless hold is set, a granted requester drops its request afterwards.
    task automatic step(input bit hold);
        int          g, b;
        logic [8:0]  ef;
        logic [3:0]  eb;
        logic [31:0] erd, era, ewa, ewd, addr;
        g = -1; b = -1; ef = '0; eb = '0;
        erd = '0; era = '0; ewa = '0; ewd = '0; addr = '0;
        @(negedge clk);
        if (rst_n) begin
            if (!m_busy) begin
                if (i_req && d_req) g = (m_last == 1) ? 0 : 1;
                else if (i_req)     g = 0;
                else if (d_req)     g = 1;
            end else if (m_t >= LAT + 1 && m_t <= LAT + BL) begin
                b = m_t - LAT - 1;
            end
            // flag order: i_gnt d_gnt i_rvalid d_rvalid d_wready i_done d_done mem_re mem_we
            if (g == 0) ef[8] = 1'b1;
            if (g == 1) ef[7] = 1'b1;
            if (b >= 0) begin
                addr = m_base + 32'(4 * b);
                eb   = 4'(b);
                if (m_we) begin
                    ef[4] = 1'b1; ef[0] = 1'b1;
                    ewa = addr; ewd = m_seed + 32'(b);
                end else begin
                    ef[(m_owner == 0) ? 6 : 5] = 1'b1; ef[1] = 1'b1;
                    era = addr; erd = ref_mem[addr[11:2]];
                end
            end
            if (m_busy && m_t == LAT + BL + 1) ef[(m_owner == 0) ? 3 : 2] = 1'b1;
        end
        check_val("flags", {55'h0, i_gnt, d_gnt, i_rvalid, d_rvalid, d_wready, i_done, d_done, mem_re, mem_we}, {55'h0, ef});
        check_val("beat", {60'h0, beat}, {60'h0, eb});
        check_val("rdata", {32'h0, rdata}, {32'h0, erd});
        check_val("mem_r_addr", {32'h0, mem_r_addr}, {32'h0, era});
        check_val("mem_w_addr", {32'h0, mem_w_addr}, {32'h0, ewa});
        check_val("mem_wd", {32'h0, mem_wd}, {32'h0, ewd});
        last_g = g;
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_last = 1;
        end else if (g >= 0) begin
            m_busy  = 1'b1;
            m_t     = 1;
            m_owner = g;
            m_we    = (g == 1) && d_we;
            m_base  = ((g == 0) ? i_addr : d_addr) & ~32'(BL * 4 - 1);
            m_seed  = wseed;
        end else if (m_busy) begin
            if (b >= 0 && m_we) ref_mem[addr[11:2]] = m_seed + 32'(b);
            if (m_t == LAT + BL + 1) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else begin
                m_t++;
            end
        end
        #1;
        if (!hold && last_g == 0) i_req = 1'b0;
        if (!hold && last_g == 1) d_req = 1'b0;
    endtask

    task automatic run_idle(input int max_cycles);
        int k;
        k = 0;
        while ((m_busy || i_req || d_req) && k < max_cycles) begin
            step(1'b0);
            k++;
        end
        check_val("idle_timeout", {63'h0, (m_busy || i_req || d_req)}, 64'h0);
    endtask

    initial begin
        int gc, fc, dc, nb;
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; wseed = '0;
        l0_i_req = 0; l0_d_req = 0; l0_d_we = 0; l0_addr = '0;
        m_busy = 0; m_t = 0; m_owner = 0; m_we = 0; m_base = '0; m_seed = '0;
        m_last = 1; last_g = -1;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
            env_mem[i] <= 32'hC0DE0000 | 32'(i);
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = 32'h11111111 * 32'(i + 1);
            env_mem[i] <= 32'h11111111 * 32'(i + 1);
        end
        #1;

        // reset, then idle with no requests
        repeat (3) step(1'b0);
        rst_n = 1'b1;
        repeat (20) step(1'b0);

        // I-cache refill of the preloaded line
        i_addr = 32'h0001000C; i_req = 1'b1;
        run_idle(20);

        // D-cache write-back, then refill of the same line
        wseed = 32'hA0; d_we = 1'b1; d_addr = 32'h00010020; d_req = 1'b1;
        run_idle(20);
        d_we = 1'b0; d_req = 1'b1;
        run_idle(20);

        // both requesters held continuously: strict alternation
        i_addr = 32'h00010100; d_addr = 32'h00010140; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        repeat (40) step(1'b1);
        i_req = 1'b0; d_req = 1'b0;
        run_idle(20);

        // reset asserted during beat 2 of a write-back
        wseed = 32'h5500; d_we = 1'b1; d_addr = 32'h00010200; d_req = 1'b1;
        for (int k = 0; k < 20 && !(m_busy && m_t == LAT + 3); k++) step(1'b0);
        check_val("reach_beat2", {63'h0, (m_busy && m_t == LAT + 3)}, 64'h1);
        rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0;
        step(1'b0);
        step(1'b0);
        rst_n = 1'b1;
        step(1'b0);
        d_we = 1'b0; d_req = 1'b1;
        run_idle(20);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (!i_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_req = 1'b1; i_addr = rand_addr();
                end
            end else if ($urandom_range(0, 19) == 0) begin
                i_req = 1'b0;
            end
            if (!d_req) begin
                if ($urandom_range(0, 3) == 0 && !(m_busy && m_owner == 1)) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_addr = rand_addr(); wseed = $urandom;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                d_req = 1'b0;
            end
            step(1'b0);
        end
        i_req = 1'b0; d_req = 1'b0;
        run_idle(20);

        // zero-latency write-back: gnt cycle 0, first beat 1, done BL+1
        l0_addr = 32'h00010044; l0_d_we = 1'b1; l0_d_req = 1'b1;
        gc = -1; fc = -1; dc = -1; nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (l0_d_gnt && gc < 0) gc = c;
            if (l0_d_wready) begin
                if (fc < 0) fc = c;
                check_val("l0_w_addr", {32'h0, l0_mem_w_addr}, {32'h0, 32'h00010040 + 32'(4 * (c - 1))});
                check_val("l0_wd", {32'h0, l0_mem_wd}, {32'h0, 32'hB0 + 32'(c - 1)});
                nb++;
            end
            if (l0_d_done && dc < 0) dc = c;
            @(posedge clk); #1;
            if (c == 0) l0_d_req = 1'b0;
        end
        check_val("l0_wgnt_cycle", 64'(gc), 64'(0));
        check_val("l0_wfirst_cycle", 64'(fc), 64'(1));
        check_val("l0_wdone_cycle", 64'(dc), 64'(BL + 1));
        check_val("l0_wbeats", 64'(nb), 64'(BL));

        // zero-latency I-cache refill
        l0_d_we = 1'b0; l0_addr = 32'h00010084; l0_i_req = 1'b1;
        gc = -1; fc = -1; dc = -1; nb = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (l0_i_gnt && gc < 0) gc = c;
            if (l0_i_rvalid) begin
                if (fc < 0) fc = c;
                check_val("l0_r_addr", {32'h0, l0_mem_r_addr}, {32'h0, 32'h00010080 + 32'(4 * (c - 1))});
                check_val("l0_rdata", {32'h0, l0_rdata}, {32'h0, (32'h00010080 + 32'(4 * (c - 1))) ^ L0_XOR});
                nb++;
            end
            if (l0_i_done && dc < 0) dc = c;
            @(posedge clk); #1;
            if (c == 0) l0_i_req = 1'b0;
        end
        check_val("l0_rgnt_cycle", 64'(gc), 64'(0));
        check_val("l0_rfirst_cycle", 64'(fc), 64'(1));
        check_val("l0_rdone_cycle", 64'(dc), 64'(BL + 1));
        check_val("l0_rbeats", 64'(nb), 64'(BL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_mem_ctrl.md
Name: dram_mem_ctrl

Overview:
Sequences the single-port main data memory (byte-addressed, combinational read, synchronous write) for two cache requesters: I-cache (line refill, read only) and D-cache (line refill or line write-back).
- Grants one line transaction at a time, with round-robin arbitration.
- Inserts a programmable access latency to model DRAM timing.
- Streams BURST_LEN word beats to or from memory.
- Sits between the cache miss handlers and the main memory model in the memwrite stage.

Parameters:
DATA_WIDTH, 32, word width (fixed at 32; one beat = 4 bytes)
ADDR_WIDTH, 32, byte address width
BURST_LEN, 4, words per cache line; power of two, 1..16
LATENCY, 2, wait cycles between grant and first beat; 0..15

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_req  in  1  I-cache line read request; held until i_gnt
i_addr  in  ADDR_WIDTH  I-cache line address (low bits ignored)
d_req  in  1  D-cache request; held until d_gnt
d_we  in  1  D-cache: 1 = write-back, 0 = refill
d_addr  in  ADDR_WIDTH  D-cache line address (low bits ignored)
d_wdata  in  DATA_WIDTH  write-back word for the current beat (combinational on beat)
i_gnt  out  1  one-cycle pulse: I-cache request accepted
d_gnt  out  1  one-cycle pulse: D-cache request accepted
beat  out  4  current beat index, 0..BURST_LEN-1
rdata  out  DATA_WIDTH  read beat data (pass-through of mem_rd)
i_rvalid  out  1  rdata valid for the I-cache this cycle
d_rvalid  out  1  rdata valid for the D-cache this cycle
d_wready  out  1  D-cache write beat is consumed this cycle
i_done  out  1  one-cycle pulse: I-cache transaction complete
d_done  out  1  one-cycle pulse: D-cache transaction complete
mem_re  out  1  memory read enable
mem_r_addr  out  ADDR_WIDTH  memory read byte address
mem_we  out  1  memory write enable
mem_w_addr  out  ADDR_WIDTH  memory write byte address
mem_wd  out  DATA_WIDTH  memory write data
mem_rd  in  DATA_WIDTH  memory read data (combinational)

Behaviour:
- States: IDLE, WAIT, BURST, DONE. The state register, counters, latched base, latched we, owner and rr_last are all reset asynchronously.
- Reset values:
  - state = IDLE, rr_last = D (so the I-cache wins the first tie), counters = 0.
  - All outputs are 0.
  - Asserting rst_n low mid-transaction aborts immediately: mem_we is deasserted and no done pulse is issued.
- IDLE:
  - If exactly one requester is asserting req, grant it.
  - If both are asserting, grant the one that is not rr_last.
  - On grant: pulse the gnt signal for one cycle and latch owner, we (forced to 0 for the I-cache), and base = addr with bits [log2(BURST_LEN*4)-1:0] cleared.
  - Next state: WAIT with wcnt = LATENCY-1, or BURST directly if LATENCY = 0.
- WAIT: decrement wcnt; move to BURST with beat = 0 when wcnt = 0. Memory enables are low.
- BURST: one beat per cycle, beat address = base + 4*beat (ADDR_WIDTH modulo arithmetic).
  - Read: mem_re = 1, mem_r_addr = beat address, rdata = mem_rd, owner's rvalid = 1.
  - Write: mem_we = 1, mem_w_addr = beat address, mem_wd = d_wdata, d_wready = 1.
  - On beat = BURST_LEN-1, move to DONE.
- DONE: pulse owner's done, set rr_last = owner, return to IDLE.
- No new grant is issued in the DONE cycle; the earliest next grant is the following IDLE cycle.
- Latency: gnt in cycle 0, first beat in cycle LATENCY+1, done in cycle LATENCY+BURST_LEN+1.
- req is ignored outside IDLE. A req that drops before being granted is simply not served.
- beat, rdata and the mem_* address and data outputs are 0 whenever not in BURST.
- Outputs are a combinational decode of registered state; there is no comb path from req to gnt other than the IDLE decode.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state_t enum (IDLE, WAIT, BURST, DONE);
  - owner_t enum (OWN_I, OWN_D);
  - WORD_BYTES = 4.
- Sub-module rr_arb2: 2-way round-robin arbiter with inputs req[1:0] and last, and a one-hot grant output; purely combinational. The controller holds rr_last.

Test Plan:
- Reset, idle: rst_n low then high with no req → all outputs 0, no mem_re/mem_we for 20 cycles.
- I-cache refill, LATENCY=2, BURST_LEN=4, i_addr=0x0001000C, memory preloaded with 0x11111111..0x44444444 at 0x00010000..0x0001000C:
  - i_gnt in cycle 0;
  - i_rvalid cycles 3-6 with rdata in that order and mem_r_addr 0x00010000, 0x04, 0x08, 0x0C;
  - i_done in cycle 7.
- D-cache write-back at d_addr=0x00010020, d_wdata = 0xA0+beat per beat:
  - mem_we for 4 cycles at 0x00010020..0x0001002C;
  - a subsequent refill of the same line returns 0xA0..0xA3.
- Simultaneous i_req and d_req held continuously:
  - the I-cache is granted first;
  - after i_done, the D-cache is granted;
  - then the I-cache again, alternating strictly.
- LATENCY=0: d_gnt in cycle 0, first beat in cycle 1, d_done in cycle BURST_LEN+1.
- Reset mid-burst: rst_n low during beat 2 of a write → mem_we drops in the same cycle, no d_done; after release the controller returns to IDLE and the next request is served normally.
